// File: rtl/secded_decodificador_pipe.sv
// Pipelined Hamming SECDED decoder with a valid/ready stream and error counters.
// Optional macro SECDED_CNT_EN builds the error counters; without it they are tied to zero.
// Codeword: in_code[i] (i < CW-1) is Hamming position i+1, in_code[CW-1] is the global parity.
module secded_decodificador_pipe #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned PAR_W = (DATA_W <= 1)   ? 2 :
                                    (DATA_W <= 4)   ? 3 :
                                    (DATA_W <= 11)  ? 4 :
                                    (DATA_W <= 26)  ? 5 :
                                    (DATA_W <= 57)  ? 6 :
                                    (DATA_W <= 120) ? 7 : 8,
    localparam int unsigned CW    = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W:0]    out_sindrome,
    output logic [1:0]        out_estado,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_simple,
    output logic [CNT_W-1:0]  cnt_doble
);

    localparam logic [1:0] EST_OK    = 2'b00;
    localparam logic [1:0] EST_CORR  = 2'b01;
    localparam logic [1:0] EST_UNCOR = 2'b10;

    // Positions (1-based) whose index has bit k set contribute to syndrome bit k.
    function automatic logic [CW-2:0] syn_mask(input int unsigned k);
        logic [CW-2:0] m;
        m = '0;
        for (int unsigned i = 0; i < CW - 1; i++) begin
            m[i] = ((i + 1) & (32'd1 << k)) != 0;
        end
        return m;
    endfunction

    // Hamming position (1-based) holding data bit j: the j-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 1;
        for (int unsigned p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              s1_valid;
    logic [CW-2:0]     s1_code;
    logic [PAR_W-1:0]  s1_s;
    logic              s1_g;

    logic              s2_adv_c;
    logic              s1_adv_c;
    logic [PAR_W-1:0]  syn_c;
    logic              glob_c;
    logic [1:0]        est_c;
    logic [CW-2:0]     fixed_c;
    logic [DATA_W-1:0] data_c;

    // Stage advance conditions; the input side is blocked while in reset.
    assign s2_adv_c = !out_valid || out_ready;
    assign s1_adv_c = !s1_valid || s2_adv_c;
    assign in_ready = s1_adv_c && !rst;

    // Syndrome and global parity of the incoming word.
    always_comb begin
        syn_c = '0;
        for (int unsigned k = 0; k < PAR_W; k++) begin
            syn_c[k] = ^(in_code[CW-2:0] & syn_mask(k));
        end
        glob_c = ^in_code;
    end

    // Classify the stage-1 word and flip the erroneous position when correctable.
    always_comb begin
        est_c   = EST_UNCOR;
        fixed_c = s1_code;
        if (s1_s == '0 && !s1_g) begin
            est_c = EST_OK;
        end else if (s1_g && (32'(s1_s) <= CW - 1)) begin
            est_c = EST_CORR;
        end
        if (est_c == EST_CORR) begin
            for (int unsigned i = 0; i < CW - 1; i++) begin
                if (32'(s1_s) == i + 1) fixed_c[i] = ~s1_code[i];
            end
        end
    end

    // Gather data bits from the non-power-of-two positions.
    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign data_c[j] = fixed_c[data_pos(j) - 1];
    end

    // Stage-1 valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 payload: raw positions, syndrome and global parity.
    always_ff @(posedge clk) begin
        if (s1_adv_c && in_valid) begin
            s1_code <= in_code[CW-2:0];
            s1_s    <= syn_c;
            s1_g    <= glob_c;
        end
    end

    // Stage-2 output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sindrome <= '0;
            out_estado   <= EST_OK;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= data_c;
                out_sindrome <= {s1_g, s1_s};
                out_estado   <= est_c;
            end
        end
    end

`ifdef SECDED_CNT_EN
    logic deliver_c;
    assign deliver_c = out_valid && out_ready;

    // Saturating error counters, updated on delivery; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (deliver_c) begin
            if (out_estado == EST_CORR && cnt_simple != '1) begin
                cnt_simple <= cnt_simple + CNT_W'(1);
            end
            if (out_estado == EST_UNCOR && cnt_doble != '1) begin
                cnt_doble <= cnt_doble + CNT_W'(1);
            end
        end
    end
`else
    logic unused_clr_c;
    assign unused_clr_c = clr_cnt;
    assign cnt_simple   = '0;
    assign cnt_doble    = '0;
`endif

endmodule

// File: tb/tb_secded_decodificador_pipe.sv
// Self-checking bench for secded_decodificador_pipe: behavioural decoder model,
// scoreboard on the default instance, plus narrow-counter and 11-bit-data instances.
module tb_secded_decodificador_pipe;

`ifdef SECDED_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] data;
        logic [4:0]  sind;
        logic [1:0]  est;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance (DATA_W=4, CNT_W=8)
    logic       in_valid0, in_ready0, out_valid0, out_ready0, clr0;
    logic [7:0] in_code0;
    logic [3:0] out_data0, out_sind0;
    logic [1:0] out_est0;
    logic [7:0] cnt_s0, cnt_d0;

    // Narrow-counter instance (CNT_W=2)
    logic       in_valid1, in_ready1, out_valid1, out_ready1, clr1;
    logic [7:0] in_code1;
    logic [3:0] out_data1, out_sind1;
    logic [1:0] out_est1;
    logic [1:0] cnt_s1, cnt_d1;

    // Wide instance (DATA_W=11, CW=16)
    logic        in_valid2, in_ready2, out_valid2, out_ready2, clr2;
    logic [15:0] in_code2;
    logic [10:0] out_data2;
    logic [4:0]  out_sind2;
    logic [1:0]  out_est2;
    logic [7:0]  cnt_s2, cnt_d2;

    secded_decodificador_pipe d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_code(in_code0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_sindrome(out_sind0), .out_estado(out_est0), .clr_cnt(clr0),
        .cnt_simple(cnt_s0), .cnt_doble(cnt_d0));

    secded_decodificador_pipe #(.DATA_W(4), .CNT_W(2)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_code(in_code1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sindrome(out_sind1), .out_estado(out_est1), .clr_cnt(clr1),
        .cnt_simple(cnt_s1), .cnt_doble(cnt_d1));

    secded_decodificador_pipe #(.DATA_W(11), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_sindrome(out_sind2), .out_estado(out_est2), .clr_cnt(clr2),
        .cnt_simple(cnt_s2), .cnt_doble(cnt_d2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    // Reference decoder: syndrome is the XOR of the positions of all set bits.
    function automatic res_t model(input int code, input int dw);
        int pw, cw, s, g, fixed, d, data;
        res_t r;
        pw = par_w(dw);
        cw = dw + pw + 1;
        s = 0;
        g = 0;
        for (int i = 0; i < cw; i++) begin
            if (((code >> i) & 1) == 1) begin
                g = g ^ 1;
                if (i < cw - 1) s = s ^ (i + 1);
            end
        end
        if (s == 0 && g == 0)           r.est = 2'd0;
        else if (g == 1 && s <= cw - 1) r.est = 2'd1;
        else                            r.est = 2'd2;
        fixed = code;
        if (r.est == 2'd1 && s != 0) fixed = fixed ^ (1 << (s - 1));
        data = 0;
        d = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                data = data | (((fixed >> (p - 1)) & 1) << d);
                d++;
            end
        end
        r.data = 11'(data);
        r.sind = 5'((g << pw) | s);
        return r;
    endfunction

    // Reference encoder producing a clean codeword.
    function automatic int encode(input int data, input int dw);
        int pw, cw, code, d, s, g;
        pw = par_w(dw);
        cw = dw + pw + 1;
        code = 0;
        d = 0;
        s = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (((data >> d) & 1) == 1) begin
                    code = code | (1 << (p - 1));
                    s = s ^ p;
                end
                d++;
            end
        end
        for (int k = 0; k < pw; k++) begin
            if (((s >> k) & 1) == 1) code = code | (1 << ((1 << k) - 1));
        end
        g = 0;
        for (int i = 0; i < cw - 1; i++) g = g ^ ((code >> i) & 1);
        return code | (g << (cw - 1));
    endfunction

    // Scoreboard for d0: expected words in flight and counter model.
    res_t q[$];
    int   m_s = 0, m_d = 0;
    bit   rst_seen = 1'b0;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready0), 32'd0);
            if (rst_seen) begin
                chk("rst_out_valid", 32'(out_valid0), 32'd0);
                chk("rst_out_data", 32'(out_data0), 32'd0);
                chk("rst_out_sind", 32'(out_sind0), 32'd0);
                chk("rst_out_est", 32'(out_est0), 32'd0);
                chk("rst_cnt_simple", 32'(cnt_s0), 32'd0);
                chk("rst_cnt_doble", 32'(cnt_d0), 32'd0);
            end
            rst_seen = 1'b1;
            q.delete();
            m_s = 0;
            m_d = 0;
        end else begin
            rst_seen = 1'b0;
            chk("in_ready", 32'(in_ready0), 32'(q.size() < 2 || out_ready0));
            if (q.size() == 0) begin
                chk("out_valid_idle", 32'(out_valid0), 32'd0);
            end else if (out_valid0) begin
                chk("sb_data", 32'(out_data0), 32'(q[0].data));
                chk("sb_sind", 32'(out_sind0), 32'(q[0].sind));
                chk("sb_est", 32'(out_est0), 32'(q[0].est));
            end
            chk("sb_cnt_simple", 32'(cnt_s0), CNT_ON ? 32'(m_s) : 32'd0);
            chk("sb_cnt_doble", 32'(cnt_d0), CNT_ON ? 32'(m_d) : 32'd0);
            if (out_valid0 && out_ready0 && q.size() > 0) begin
                e = q.pop_front();
                if (!clr0) begin
                    if (e.est == 2'd1 && m_s < 255) m_s++;
                    if (e.est == 2'd2 && m_d < 255) m_d++;
                end
            end
            if (clr0) begin
                m_s = 0;
                m_d = 0;
            end
            if (in_valid0 && in_ready0) q.push_back(model(int'(in_code0), 4));
        end
    end

    // One word through d0 with out_ready high: checks the two-cycle latency.
    task automatic directed(input logic [7:0] c, input logic [3:0] ed, input logic [3:0] es,
                            input logic [1:0] st, input string nm);
        in_valid0 = 1'b1;
        in_code0  = c;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_valid"}, 32'(out_valid0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid0), 32'd1);
        chk({nm, "_data"}, 32'(out_data0), 32'(ed));
        chk({nm, "_sind"}, 32'(out_sind0), 32'(es));
        chk({nm, "_est"}, 32'(out_est0), 32'(st));
        @(posedge clk); #1;
    endtask

    initial begin
        res_t r;
        int   c, dat, mode, b1, b2;

        rst = 1'b1;
        in_valid0 = 1'b0; in_code0 = '0; out_ready0 = 1'b1; clr0 = 1'b0;
        in_valid1 = 1'b0; in_code1 = '0; out_ready1 = 1'b1; clr1 = 1'b0;
        in_valid2 = 1'b0; in_code2 = '0; out_ready2 = 1'b1; clr2 = 1'b0;

        // Pin the reference model to hand-computed values.
        r = model(32'h55, 4);
        chk("model_55_data", 32'(r.data), 32'hB);
        chk("model_55_est", 32'(r.est), 32'd0);
        r = model(32'h45, 4);
        chk("model_45_sind", 32'(r.sind), 32'hD);
        chk("model_45_data", 32'(r.data), 32'hB);
        r = model(32'h56, 4);
        chk("model_56_est", 32'(r.est), 32'd2);
        chk("model_enc_B", 32'(encode(32'hB, 4)), 32'h55);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;

        directed(8'h55, 4'hB, 4'b0000, 2'b00, "clean");
        directed(8'h45, 4'hB, 4'b1101, 2'b01, "single");
        @(negedge clk);
        chk("single_cnt", 32'(cnt_s0), CNT_ON ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        directed(8'hD5, 4'hB, 4'b1000, 2'b01, "gpar");
        directed(8'h56, 4'hB, 4'b0011, 2'b10, "double");
        @(negedge clk);
        chk("double_cnt", 32'(cnt_d0), CNT_ON ? 32'd1 : 32'd0);
        @(posedge clk); #1;

        // Backpressure: three words offered while the consumer stalls.
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_code0   = 8'h55;
        @(posedge clk); #1;
        in_code0 = 8'h45;
        @(posedge clk); #1;
        in_code0 = 8'h56;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_data", 32'(out_data0), 32'hB);
            chk("bp_hold_est", 32'(out_est0), 32'd0);
            chk("bp_hold_in_ready", 32'(in_ready0), 32'd0);
        end
        @(posedge clk); #1;
        out_ready0 = 1'b1;
        @(negedge clk);
        chk("bp_w0_est", 32'(out_est0), 32'd0);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("bp_w1_est", 32'(out_est0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_w2_est", 32'(out_est0), 32'd2);
        @(posedge clk); #1;

        // Randomized traffic with backpressure, clears and one mid-stream reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) rst = 1'b1;
            if (cyc == 1503) rst = 1'b0;
            dat  = int'($urandom % 16);
            mode = int'($urandom % 4);
            c    = encode(dat, 4);
            case (mode)
                1: c = c ^ (1 << int'($urandom % 8));
                2: begin
                    b1 = int'($urandom % 8);
                    b2 = (b1 + 1 + int'($urandom % 7)) % 8;
                    c  = c ^ (1 << b1) ^ (1 << b2);
                end
                3: c = int'($urandom % 256);
                default: ;
            endcase
            in_valid0  = ($urandom % 4) != 0;
            in_code0   = 8'(c);
            out_ready0 = ($urandom % 3) != 0;
            clr0       = ($urandom % 64) == 0;
            @(posedge clk); #1;
        end
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        clr0       = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;

        // Narrow counters: saturation at 3, then clear racing a delivery.
        in_valid1 = 1'b1;
        in_code1  = 8'h45;
        repeat (5) begin
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_simple", 32'(cnt_s1), CNT_ON ? 32'd3 : 32'd0);
        chk("sat_cnt_doble", 32'(cnt_d1), 32'd0);
        @(posedge clk); #1;
        in_valid1 = 1'b1;
        in_code1  = 8'h56;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("d1_cnt_doble", 32'(cnt_d1), CNT_ON ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        in_valid1 = 1'b1;
        in_code1  = 8'h56;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        clr1 = 1'b1;
        @(negedge clk);
        chk("clr_pending_valid", 32'(out_valid1), 32'd1);
        @(posedge clk); #1;
        clr1 = 1'b0;
        @(negedge clk);
        chk("clr_cnt_doble", 32'(cnt_d1), 32'd0);
        chk("clr_cnt_simple", 32'(cnt_s1), 32'd0);
        @(posedge clk); #1;

        // Wide instance: any single flipped bit restores the original data.
        for (int it = 0; it < 40; it++) begin
            dat = int'($urandom % 2048);
            c   = encode(dat, 11) ^ (1 << int'($urandom % 16));
            r   = model(c, 11);
            in_valid2 = 1'b1;
            in_code2  = 16'(c);
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("w11_valid", 32'(out_valid2), 32'd1);
            chk("w11_data", 32'(out_data2), 32'(dat));
            chk("w11_est", 32'(out_est2), 32'd1);
            chk("w11_sind", 32'(out_sind2), 32'(r.sind));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
